// File: rtl/digital_inputs.sv
// digital_inputs: timestamps edges on eight async input lines and streams each one as a 3-word AXI4-Stream packet
// Ports: clk, resetn (async active-low); input_clk (ignored); run, inputs[7:0] (async);
//   cfg_addr/cfg_wdata/cfg_we/cfg_rdata register port (0 enable, 1 sticky overflow, 2 edge masks);
//   m_axis_tvalid/tdata/tlast/tready stream master.
// Option: DIGITAL_INPUTS_EDGE_MASK_EN adds addr 2 = {fall_en[7:0], rise_en[7:0]}.
module digital_inputs #(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int CONFIG_REG_DATA_WIDTH = 32,
  parameter int CONFIG_REG_ADDR_WIDTH = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic input_clk,
  input  logic run,
  input  logic [7:0] inputs,
  input  logic [CONFIG_REG_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [CONFIG_REG_DATA_WIDTH-1:0] cfg_wdata,
  input  logic cfg_we,
  output logic [CONFIG_REG_DATA_WIDTH-1:0] cfg_rdata,
  output logic m_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic m_axis_tlast,
  input  logic m_axis_tready
);
  localparam int TW = TIMESTAMP_WIDTH;
  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam logic [CONFIG_REG_ADDR_WIDTH-1:0] A_EN = 0;
  localparam logic [CONFIG_REG_ADDR_WIDTH-1:0] A_OVF = 1;
  localparam logic [CONFIG_REG_ADDR_WIDTH-1:0] A_MASK = 2;
  logic [8:0] sync1, sync2;
  logic [7:0] in_sync, prev, pend, pol, edge_det, ev, free, keep, avail, cap;
  logic [TW-1:0] ts_cnt;
  logic [TW-1:0] slot_ts [8];
  logic [15:0] mask_rd;
  logic [1:0] beat;
  logic [2:0] sel, pick;
  logic enable, overflow, run_g, accept, done, start, ovf_hit;
  logic unused;
  assign unused = ^{input_clk, cfg_wdata};
  // run shares the input synchronizer so event timestamps keep their alignment to run
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {run, inputs};
      sync2 <= sync1;
    end
  assign in_sync = sync2[7:0];
  assign run_g = sync2[8] & enable;
  assign edge_det = run_g ? (in_sync ^ prev) : 8'h00;
`ifdef DIGITAL_INPUTS_EDGE_MASK_EN
  logic [7:0] rise_en, fall_en;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) {fall_en, rise_en} <= 16'hFFFF;
    else if (cfg_we && cfg_addr == A_MASK) {fall_en, rise_en} <= cfg_wdata[15:0];
  assign ev = edge_det & ((in_sync & rise_en) | (~in_sync & fall_en));
  assign mask_rd = {fall_en, rise_en};
`else
  assign ev = edge_det;
  assign mask_rd = '0;
`endif
  assign accept = m_axis_tvalid & m_axis_tready;
  assign done = accept & (beat == 2'd2);
  assign free = done ? (8'h01 << sel) : 8'h00;
  // once run_g drops only the slot currently on the wire survives
  assign keep = run_g ? 8'hFF : (m_axis_tvalid ? (8'h01 << sel) : 8'h00);
  // a slot being freed this cycle may be refilled by a new edge in the same cycle
  assign avail = pend & ~free;
  assign cap = ev & ~avail;
  assign ovf_hit = |(ev & avail);
  assign start = (!m_axis_tvalid | done) & run_g & (|avail);
  always_comb begin
    pick = 3'd0;
    for (int i = 7; i >= 0; i--) if (avail[i]) pick = 3'(i);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      prev <= '0;
      pend <= '0;
      pol <= '0;
      ts_cnt <= '0;
      for (int i = 0; i < 8; i++) slot_ts[i] <= '0;
    end else begin
      prev <= run_g ? in_sync : 8'h00;
      ts_cnt <= run_g ? ts_cnt + 1'b1 : '0;
      pend <= (pend & ~free & keep) | cap;
      for (int i = 0; i < 8; i++)
        if (cap[i]) begin
          pol[i] <= in_sync[i];
          slot_ts[i] <= ts_cnt;
        end
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      enable <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (cfg_we && cfg_addr == A_EN) enable <= cfg_wdata[0];
      overflow <= (overflow & !(cfg_we && cfg_addr == A_OVF)) | ovf_hit;
    end
  always_comb
    cfg_rdata = (cfg_addr == A_EN) ? CONFIG_REG_DATA_WIDTH'(enable) :
                (cfg_addr == A_OVF) ? CONFIG_REG_DATA_WIDTH'(overflow) :
                (cfg_addr == A_MASK) ? CONFIG_REG_DATA_WIDTH'(mask_rd) : '0;
  // start has priority so the next packet follows the last beat with no idle cycle
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      beat <= 2'd0;
      sel <= 3'd0;
    end else if (start) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata <= {pol[pick], {(DW-4){1'b0}}, pick};
      m_axis_tlast <= 1'b0;
      beat <= 2'd0;
      sel <= pick;
    end else if (accept) begin
      if (beat == 2'd2) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tdata <= '0;
        m_axis_tlast <= 1'b0;
        beat <= 2'd0;
      end else if (beat == 2'd0) begin
        m_axis_tdata <= slot_ts[sel][TW-1:DW];
        beat <= 2'd1;
      end else begin
        m_axis_tdata <= slot_ts[sel][DW-1:0];
        m_axis_tlast <= 1'b1;
        beat <= 2'd2;
      end
    end
endmodule

// File: tb/tb_digital_inputs.sv
// tb_digital_inputs: scoreboard bench for digital_inputs
module tb_digital_inputs;
  logic clk = 0, resetn = 0, input_clk = 0, run = 0, cfg_we = 0, tready = 1;
  logic tvalid, tlast;
  logic [7:0] inputs = 0;
  logic [2:0] cfg_addr = 0;
  logic [31:0] cfg_wdata = 0, cfg_rdata, tdata, rd;
  int checks = 0, errors = 0, tlast_n = 0, beats = 0;
  longint cyc = 0, base = 0;
  bit armed = 0, rnd = 0, stalled = 0;
  logic [32:0] q[$];
  logic [32:0] held, exp_w;

  digital_inputs dut (
    .clk(clk), .resetn(resetn), .input_clk(input_clk), .run(run), .inputs(inputs),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_we(cfg_we), .cfg_rdata(cfg_rdata),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tlast(tlast), .m_axis_tready(tready)
  );

  always #5 clk = ~clk;
  always #7 input_clk = ~input_clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stream monitor: pops expected words on each transfer, checks hold while stalled
  always @(negedge clk) begin
    if (stalled && tvalid) begin
      checks++;
      if ({tlast, tdata} !== held) begin
        errors++;
        $display("FAIL stall_hold got %h want %h", {tlast, tdata}, held);
      end
    end
    if (tvalid && tready) begin
      beats++;
      if (tlast) tlast_n++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL stream_word got %h want nothing", {tlast, tdata});
      end else begin
        exp_w = q.pop_front();
        if ({tlast, tdata} !== exp_w) begin
          errors++;
          $display("FAIL stream_word got %h want %h", {tlast, tdata}, exp_w);
        end
      end
    end
    stalled = tvalid && !tready;
    held = {tlast, tdata};
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd) tready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic push_ev(input logic [2:0] ch, input logic p, input logic [63:0] ts);
    q.push_back({1'b0, p, 28'b0, ch});
    q.push_back({1'b0, ts[63:32]});
    q.push_back({1'b1, ts[31:0]});
  endtask

  task automatic set_inputs(input logic [7:0] v);
    logic [7:0] d;
    d = v ^ inputs;
    if (armed)
      for (int i = 0; i < 8; i++) if (d[i]) push_ev(3'(i), v[i], cyc - base);
    inputs = v;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_addr = a;
    cfg_wdata = d;
    cfg_we = 1;
    step(1);
    cfg_we = 0;
  endtask

  task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic test_reset;
    resetn = 0;
    step(3);
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    checks++;
    if (tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", tdata); end
    checks++;
    if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", tlast); end
    for (int a = 0; a < 3; a++) begin
      cfg_read(3'(a), rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h want 0", a, rd); end
    end
    resetn = 1;
    step(2);
  endtask

  task automatic test_single;
    cfg_write(0, 1);
    run = 1;
    base = cyc;
    armed = 1;
    set_inputs(8'h01);
    step(100);
    set_inputs(8'h00);
    step(200);
    set_inputs(8'h02);
    step(100);
    set_inputs(8'h00);
    step(200);
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL single_drain got %0d left want 0", q.size()); end
    checks++;
    if (tlast_n != 4) begin errors++; $display("FAIL single_tlast got %0d want 4", tlast_n); end
  endtask

  task automatic test_burst;
    int lat, b0;
    rnd = 1;
    set_inputs(8'hFF);
    step(100);
    rnd = 0;
    tready = 1;
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL burst_rise_drain got %0d left want 0", q.size()); end
    set_inputs(8'h00);
    lat = 0;
    while (!tvalid && lat < 6) begin step(1); lat++; end
    checks++;
    if (!tvalid || lat > 4) begin errors++; $display("FAIL latency got %0d cycles want <=4", lat); end
    b0 = beats;
    step(24);
    checks++;
    if (beats - b0 != 24) begin errors++; $display("FAIL back_to_back got %0d beats want 24", beats - b0); end
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL burst_idle got %b want 0", tvalid); end
    checks++;
    if (tlast_n != 20) begin errors++; $display("FAIL total_tlast got %0d want 20", tlast_n); end
    cfg_read(1, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL burst_overflow got %h want 0", rd); end
  endtask

  task automatic test_overflow;
    tready = 0;
    set_inputs(8'h08);
    step(5);
    inputs = 8'h00;
    step(10);
    checks++;
    if (tvalid !== 1'b1) begin errors++; $display("FAIL ovf_stalled got %b want 1", tvalid); end
    cfg_read(1, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL ovf_set got %h want 1", rd); end
    tready = 1;
    step(6);
    checks++;
    if (q.size() != 0 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_one_packet got %0d left tvalid %b want 0 0", q.size(), tvalid);
    end
    cfg_write(1, 0);
    cfg_read(1, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL ovf_clear got %h want 0", rd); end
  endtask

  task automatic test_disable;
    armed = 0;
    cfg_write(0, 0);
    inputs = 8'h55;
    step(5);
    inputs = 8'h10;
    step(5);
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL disabled_quiet got %b want 0", tvalid); end
    base = cyc - 1;
    cfg_write(0, 1);
    armed = 1;
    push_ev(3'd4, 1'b1, 64'd0);
    step(20);
    set_inputs(8'h00);
    step(30);
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL reenable_drain got %0d left want 0", q.size()); end
  endtask

  task automatic test_reset_mid;
    tready = 0;
    set_inputs(8'h20);
    step(6);
    checks++;
    if (tvalid !== 1'b1) begin errors++; $display("FAIL midpkt_valid got %b want 1", tvalid); end
    resetn = 0;
    #1;
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL async_reset_tvalid got %b want 0", tvalid); end
    checks++;
    if (tdata !== 32'h0) begin errors++; $display("FAIL async_reset_tdata got %h want 0", tdata); end
    q.delete();
    armed = 0;
    tready = 1;
    step(2);
    resetn = 1;
    step(2);
    cfg_read(0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_enable got %h want 0", rd); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_overflow;
    test_disable;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
